// File: rtl/mux_nto1_pipe_pkg.sv
// Shared constants and helpers for the N:1 pipelined selector and its arbiter.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Channel-index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Bundle of the producer-lane inputs, downstream handshake and status of mux_nto1_pipe.
interface mux_nto1_pipe_if #(
  parameter int N     = 4,
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
);
  import mux_pkg::*;

  localparam int CW = clog2_min1(N);

  logic                 mode;
  logic [CW-1:0]        sel;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CW-1:0]        out_chan;
  logic [CNT_W-1:0]     xfer_cnt;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, xfer_cnt
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, xfer_cnt
  );

endinterface

// File: rtl/mux_nto1_pipe_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] grant_idx
);

  localparam int SW = CW + 1;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [CW-1:0]  off;
  logic [SW-1:0]  idx_sum;
  logic           any_req;

  always_comb begin
    // Rotate so ptr lands at bit 0, pick the lowest set bit, rotate the index back.
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N];
    any_req = |req;
    off     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) off = CW'(i);
    end
    idx_sum = {1'b0, off} + {1'b0, ptr};
    if (idx_sum >= SW'(N)) idx_sum = idx_sum - SW'(N);
    grant_idx = idx_sum[CW-1:0];
    grant     = '0;
    if (any_req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-channel selector with per-lane valid/ready, explicit or round-robin choice, one registered output stage.
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_nto1_pipe_if.slave bus
);

  localparam int CW = clog2_min1(N);
  localparam int SW = CW + 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CW-1:0]    out_chan_q,  out_chan_d;
  logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;
  logic [CW-1:0]    rr_ptr_q,    rr_ptr_d;

  logic [N-1:0]     rr_grant;
  logic [CW-1:0]    rr_idx;
  logic [N-1:0]     sel_grant;
  logic [N-1:0]     grant;
  logic [CW-1:0]    grant_idx;
  logic [N-1:0]     in_ready;
  logic             free;
  logic             accept;
  logic [WIDTH-1:0] pick_data;
  logic [SW-1:0]    ptr_inc;

  rr_arbiter #(
    .N  (N),
    .CW (CW)
  ) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  always_comb begin
    free = !out_valid_q || bus.out_ready;

    // An out-of-range sel simply matches no channel, so nothing is granted.
    sel_grant = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == CW'(k)) sel_grant[k] = bus.in_valid[k];
    end

    if (bus.mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant     = sel_grant;
      grant_idx = bus.sel;
    end

    in_ready = (rst_n && free) ? grant : '0;
    accept   = |(bus.in_valid & in_ready);

    // Pure AND/OR lane selection keyed by the one-hot ready vector.
    pick_data = '0;
    for (int k = 0; k < N; k++) begin
      pick_data = pick_data | (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{in_ready[k]}});
    end

    ptr_inc = {1'b0, grant_idx} + SW'(1);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    xfer_cnt_d  = xfer_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = pick_data;
      out_chan_d  = grant_idx;
      xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
      if (bus.mode == MODE_RR) begin
        rr_ptr_d = (ptr_inc == SW'(N)) ? '0 : ptr_inc[CW-1:0];
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      xfer_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule
